// File: rtl/iterative_multiplier_if.sv
// Handshake bundle for the iterative multiplier: the operand/mode request on the input side
// and the answer/result response on the output side.
interface iterative_multiplier_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   operator_1;
    logic [WIDTH-1:0]   operator_2;
    logic [1:0]         mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] answer;
    logic [WIDTH-1:0]   result;

    modport master (
        output in_valid, operator_1, operator_2, mode, out_ready,
        input  in_ready, out_valid, answer, result
    );

    modport slave (
        input  in_valid, operator_1, operator_2, mode, out_ready,
        output in_ready, out_valid, answer, result
    );
endinterface

// File: rtl/iterative_multiplier.sv
// Chunk-serial WIDTH x WIDTH multiplier with RISC-V MUL/MULH/MULHSU/MULHU signedness.
// Optional macro MUL_ZERO_SKIP_EN: a zero operand bypasses accumulation and answers in one edge.
module iterative_multiplier #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    iterative_multiplier_if.slave bus
);
    localparam int N   = WIDTH / CHUNK;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int SHW = $clog2(2 * WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               neg_q, neg_d;
    logic [1:0]         mode_q, mode_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] answer_q, answer_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CW-1:0]      i_q, i_d, j_q, j_d;
    logic               out_valid_q, out_valid_d;

    logic [CHUNK-1:0]   a_chunk [N];
    logic [CHUNK-1:0]   b_chunk [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_chunks
        assign a_chunk[gi] = a_q[gi*CHUNK +: CHUNK];
        assign b_chunk[gi] = b_q[gi*CHUNK +: CHUNK];
    end

    // Operand sign handling: op1 signed for MULH/MULHSU, op2 signed for MULH only.
    logic               s1, s2;
    logic [WIDTH-1:0]   mag1, mag2;
    always_comb begin
        s1   = ((bus.mode == 2'b01) || (bus.mode == 2'b10)) && bus.operator_1[WIDTH-1];
        s2   = (bus.mode == 2'b01) && bus.operator_2[WIDTH-1];
        mag1 = s1 ? (~bus.operator_1 + WIDTH'(1)) : bus.operator_1;
        mag2 = s2 ? (~bus.operator_2 + WIDTH'(1)) : bus.operator_2;
    end

    logic [2*CHUNK-1:0] pp;
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] pp_shift;
    logic [2*WIDTH-1:0] fix_val;
    always_comb begin
        pp       = (2*CHUNK)'(a_chunk[i_q]) * (2*CHUNK)'(b_chunk[j_q]);
        shamt    = SHW'(CHUNK * (int'(i_q) + int'(j_q)));
        pp_shift = (2*WIDTH)'(pp) << shamt;
        fix_val  = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        neg_d       = neg_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        i_d         = i_q;
        j_d         = j_q;
        answer_d    = answer_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = mag1;
                    b_d     = mag2;
                    neg_d   = s1 ^ s2;
                    mode_d  = bus.mode;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = CALC;
`ifdef MUL_ZERO_SKIP_EN
                    if ((bus.operator_1 == '0) || (bus.operator_2 == '0)) begin
                        answer_d    = '0;
                        result_d    = '0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
`endif
                end
            end
            CALC: begin
                acc_d = acc_q + pp_shift;
                if (j_q == CW'(N - 1)) begin
                    j_d = '0;
                    if (i_q == CW'(N - 1)) begin
                        state_d = FIX;
                    end else begin
                        i_d = i_q + CW'(1);
                    end
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
            FIX: begin
                answer_d    = fix_val;
                result_d    = (mode_q == 2'b00) ? fix_val[WIDTH-1:0] : fix_val[2*WIDTH-1:WIDTH];
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            neg_q       <= 1'b0;
            mode_q      <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            answer_q    <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            neg_q       <= neg_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            i_q         <= i_d;
            j_q         <= j_d;
            answer_q    <= answer_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.answer    = answer_q;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_iterative_multiplier.sv
// Directed bench for iterative_multiplier: signedness modes, latency, backpressure, reset abort
// and the zero-operand path (MUL_ZERO_SKIP_EN aware).
module tb_iterative_multiplier;
    localparam int LAT = 5;
`ifdef MUL_ZERO_SKIP_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 5;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    iterative_multiplier_if #(.WIDTH(32)) bus ();

    iterative_multiplier #(.WIDTH(32), .CHUNK(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Edges after the accept edge until out_valid is seen (inputs/outputs touched at posedge+1).
    task automatic start_and_wait(input string tag, input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] m, input logic [63:0] exp_ans,
                                  input logic [31:0] exp_res, input int exp_lat);
        int n;
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.operator_1 = a;
        bus.operator_2 = b;
        bus.mode       = m;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " answer"}, bus.answer, exp_ans);
        chk({tag, " result"}, 64'(bus.result), 64'(exp_res));
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] m, input logic [63:0] exp_ans,
                          input logic [31:0] exp_res, input int exp_lat);
        start_and_wait(tag, a, b, m, exp_ans, exp_res, exp_lat);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, " consumed out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, " consumed in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.operator_1 = '0;
        bus.operator_2 = '0;
        bus.mode       = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset answer", bus.answer, 64'd0);
        chk("reset result", 64'(bus.result), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("ff MUL",    32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 64'hFFFFFFFE00000001, 32'h00000001, LAT);
        run_op("ff MULH",   32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 64'h0000000000000001, 32'h00000000, LAT);
        run_op("ff MULHSU", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 64'hFFFFFFFF00000001, 32'hFFFFFFFF, LAT);
        run_op("ff MULHU",  32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 64'hFFFFFFFE00000001, 32'hFFFFFFFE, LAT);
        run_op("minneg MULH",  32'h80000000, 32'h80000000, 2'b01, 64'h4000000000000000, 32'h40000000, LAT);
        run_op("minneg MULHU", 32'h80000000, 32'h80000000, 2'b11, 64'h4000000000000000, 32'h40000000, LAT);
        run_op("neg2x3 MULHSU", 32'hFFFFFFFE, 32'h00000003, 2'b10, 64'hFFFFFFFFFFFFFFFA, 32'hFFFFFFFF, LAT);
        run_op("7xneg3 MULH",   32'h00000007, 32'hFFFFFFFD, 2'b01, 64'hFFFFFFFFFFFFFFEB, 32'hFFFFFFFF, LAT);
        run_op("3xff MULHSU",   32'h00000003, 32'hFFFFFFFF, 2'b10, 64'h00000002FFFFFFFD, 32'h00000002, LAT);
        run_op("zero MULHU",    32'h00000000, 32'h12345678, 2'b11, 64'h0000000000000000, 32'h00000000, ZLAT);

        // Backpressure: result must hold while inputs churn and in_valid stays high.
        start_and_wait("bp", 32'h00010000, 32'h00010000, 2'b00, 64'h0000000100000000, 32'h00000000, LAT);
        for (int c = 0; c < 10; c++) begin
            bus.operator_1 = $urandom;
            bus.operator_2 = $urandom;
            bus.mode       = 2'($urandom_range(0, 3));
            bus.in_valid   = 1'b1;
            @(posedge clk);
            #1;
            chk("bp hold answer", bus.answer, 64'h0000000100000000);
            chk("bp hold out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp hold in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("bp release out_valid", 64'(bus.out_valid), 64'd0);
        chk("bp release in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("bp idle in_ready", 64'(bus.in_ready), 64'd1);

        // Reset two cycles into CALC aborts the operation.
        bus.operator_1 = 32'hFFFFFFFF;
        bus.operator_2 = 32'hFFFFFFFF;
        bus.mode       = 2'b11;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort answer", bus.answer, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen++;
        end
        chk("abort no stale out_valid", 64'(seen), 64'd0);
        run_op("post-reset MULHU", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 64'hFFFFFFFE00000001, 32'hFFFFFFFE, LAT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
